// File: rtl/memory_arbiter_pkg.sv
// Shared state encoding, port identifiers and default widths for the memory arbiter.
package memory_arbiter_pkg;

   localparam int          DEFAULT_ADDR_WIDTH     = 32;
   localparam int          DEFAULT_DATA_WIDTH     = 32;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_INST = 2'd1,
      STATE_DATA = 2'd2
   } state_t;

   typedef enum logic {
      PORT_INST = 1'b0,
      PORT_DATA = 1'b1
   } port_t;

endpackage

// File: rtl/bus_watchdog.sv
// Counts unacknowledged bus cycles and flags the cycle in which the access must be aborted.
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic active,
   input  logic ack,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Saturates at LIMIT so a lingering count can never wrap before the next grant clears it.
   always_ff @(posedge clock) begin
      if (reset || start) begin
         count <= '0;
      end else if (active && !ack && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = active && !ack && (count == LIMIT);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the shared memory bus between the fetch and load/store ports.
// Optional round-robin tie-breaking is enabled by defining MEMORY_ARBITER_ROUND_ROBIN_EN.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int          ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
   parameter int          DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    inst_request,
   input  logic [ADDR_WIDTH-1:0]   inst_address,
   output logic [DATA_WIDTH-1:0]   inst_rdata,
   output logic                    inst_ready,
   input  logic                    data_request,
   input  logic                    data_write,
   input  logic [DATA_WIDTH/8-1:0] data_select,
   input  logic [ADDR_WIDTH-1:0]   data_address,
   input  logic [DATA_WIDTH-1:0]   data_wdata,
   output logic [DATA_WIDTH-1:0]   data_rdata,
   output logic                    data_ready,
   output logic                    bus_request,
   output logic                    bus_write,
   output logic [DATA_WIDTH/8-1:0] bus_select,
   output logic [ADDR_WIDTH-1:0]   bus_address,
   output logic [DATA_WIDTH-1:0]   bus_wdata,
   input  logic [DATA_WIDTH-1:0]   bus_rdata,
   input  logic                    bus_ack,
   output logic                    bus_error,
   output logic                    stall_request
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   state_t                state, state_next;
   logic                  bus_request_next;
   logic                  bus_write_next;
   logic [SEL_WIDTH-1:0]  bus_select_next;
   logic [ADDR_WIDTH-1:0] bus_address_next;
   logic [DATA_WIDTH-1:0] bus_wdata_next;
   logic [DATA_WIDTH-1:0] inst_rdata_next;
   logic [DATA_WIDTH-1:0] data_rdata_next;
   logic                  inst_ready_next;
   logic                  data_ready_next;
   logic                  bus_error_next;

   logic  inst_pend;
   logic  data_pend;
   logic  ack_seen;
   logic  expired;
   logic  done;
   logic  can_inst;
   logic  can_data;
   logic  grant;
   port_t grant_port;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
   port_t last_port;
`endif

   bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock  (clock),
      .reset  (reset),
      .start  (grant),
      .active (bus_request),
      .ack    (bus_ack),
      .expired(expired)
   );

   // A port whose ready pulse is out this cycle is not pending, so its still-held request is not re-granted.
   always_comb begin
      inst_pend = inst_request && !inst_ready;
      data_pend = data_request && !data_ready;
      ack_seen  = bus_request && bus_ack;
      done      = ack_seen || expired;
      can_inst  = 1'b0;
      can_data  = 1'b0;
      case (state)
         STATE_IDLE: begin
            can_inst = inst_pend;
            can_data = data_pend;
         end
         STATE_INST: can_data = done && data_pend;
         STATE_DATA: can_inst = done && inst_pend;
         default: ;
      endcase
      grant = can_inst || can_data;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      if (can_inst && can_data) begin
         grant_port = (last_port == PORT_DATA) ? PORT_INST : PORT_DATA;
      end else begin
         grant_port = can_data ? PORT_DATA : PORT_INST;
      end
`else
      grant_port = can_data ? PORT_DATA : PORT_INST;
`endif
   end

   always_comb begin
      state_next       = state;
      bus_request_next = bus_request;
      bus_write_next   = bus_write;
      bus_select_next  = bus_select;
      bus_address_next = bus_address;
      bus_wdata_next   = bus_wdata;
      inst_rdata_next  = '0;
      data_rdata_next  = '0;
      inst_ready_next  = 1'b0;
      data_ready_next  = 1'b0;
      bus_error_next   = 1'b0;

      if ((state != STATE_IDLE) && done) begin
         bus_error_next = !ack_seen;
         if (state == STATE_INST) begin
            inst_ready_next = 1'b1;
            inst_rdata_next = ack_seen ? bus_rdata : '0;
         end else begin
            data_ready_next = 1'b1;
            data_rdata_next = (ack_seen && !bus_write) ? bus_rdata : '0;
         end
         state_next       = STATE_IDLE;
         bus_request_next = 1'b0;
         bus_write_next   = 1'b0;
         bus_select_next  = '0;
         bus_address_next = '0;
         bus_wdata_next   = '0;
      end

      // A grant in the completion cycle overrides the return to idle, giving back-to-back cycles.
      if (grant) begin
         bus_request_next = 1'b1;
         if (grant_port == PORT_DATA) begin
            state_next       = STATE_DATA;
            bus_write_next   = data_write;
            bus_select_next  = data_select;
            bus_address_next = data_address;
            bus_wdata_next   = data_write ? data_wdata : '0;
         end else begin
            state_next       = STATE_INST;
            bus_write_next   = 1'b0;
            bus_select_next  = '1;
            bus_address_next = inst_address;
            bus_wdata_next   = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= STATE_IDLE;
         bus_request <= 1'b0;
         bus_write   <= 1'b0;
         bus_select  <= '0;
         bus_address <= '0;
         bus_wdata   <= '0;
         inst_rdata  <= '0;
         data_rdata  <= '0;
         inst_ready  <= 1'b0;
         data_ready  <= 1'b0;
         bus_error   <= 1'b0;
      end else begin
         state       <= state_next;
         bus_request <= bus_request_next;
         bus_write   <= bus_write_next;
         bus_select  <= bus_select_next;
         bus_address <= bus_address_next;
         bus_wdata   <= bus_wdata_next;
         inst_rdata  <= inst_rdata_next;
         data_rdata  <= data_rdata_next;
         inst_ready  <= inst_ready_next;
         data_ready  <= data_ready_next;
         bus_error   <= bus_error_next;
      end
   end

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
   // Starts as "data granted last" so the first tie goes to fetch.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_port <= PORT_DATA;
      end else if (grant) begin
         last_port <= grant_port;
      end
   end
`endif

   assign stall_request = inst_pend || data_pend;

endmodule
